// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM states and default sizes.
package dmem_arb_pkg;

    localparam int AW_DEF         = 12;
    localparam int DW_DEF         = 32;
    localparam int STARVE_MAX_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    // Width of a counter that must reach max_val-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Counts consecutive cycles a pending debug read has lost the RAM port to
// the CPU. sat tells the arbiter that the next grant must be forced.
module arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int            CW      = cnt_width(STARVE_MAX);
    localparam logic [CW-1:0] SAT_VAL = CW'(STARVE_MAX - 1);

    logic [CW-1:0] cnt_q;

    // Starve count: clear wins over increment, and the count never passes SAT_VAL
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clr)
            cnt_q <= '0;
        else if (inc && (cnt_q != SAT_VAL))
            cnt_q <= cnt_q + 1'b1;
    end

    assign sat = (cnt_q == SAT_VAL);

endmodule

// File: rtl/dmem_arb.sv
// Single-port data-RAM arbiter between the CPU MEM stage and a debug/display
// reader. The CPU normally owns the port; a pending debug read is served in
// any cycle the CPU leaves free, or forced (stalling the CPU for one cycle)
// after it has been starved for STARVE_MAX-1 cycles.
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          cpu_re,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [31:0]   stall_cnt
);

    arb_state_t state_q, state_d;
    logic       cpu_acc;
    logic       grant;
    logic       starve_sat;
    logic       cnt_inc;
    logic       cnt_clr;

    // A store and a load in the same cycle is treated as a store
    assign cpu_acc = cpu_re | cpu_we;

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk (clk),
        .rst (RST),
        .inc (cnt_inc),
        .clr (cnt_clr),
        .sat (starve_sat)
    );

    // FSM state register
    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state and starve-counter control; ACK ignores dbg_req entirely
    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE, WAIT: begin
                if (grant) begin
                    state_d = ACK;
                    cnt_clr = 1'b1;
                end else if (dbg_req) begin
                    state_d = WAIT;
                    cnt_inc = 1'b1;
                end else begin
                    // A request withdrawn while waiting abandons the wait
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Grant decision and RAM port mux; a forced grant blocks the CPU write and stalls it
    always_comb begin
        grant     = !RST && ((state_q == IDLE) || (state_q == WAIT)) && dbg_req
                    && (!cpu_acc || starve_sat);
        cpu_stall = grant && cpu_acc;
        mem_addr  = grant ? dbg_addr : cpu_addr;
        mem_we    = !RST && !grant && cpu_we;
        mem_wdata = cpu_wdata;
        cpu_rdata = mem_rdata;
    end

    // Debug read return: ack pulses the cycle after a grant, data held until the next grant
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            dbg_ack <= grant;
            if (grant)
                dbg_rdata <= mem_rdata;
        end
    end

    // Stall statistics, wrapping at 2^32
    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            stall_cnt <= '0;
        else if (cpu_stall)
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule

// File: tb/tb_dmem_arb.sv
// Self-checking bench for dmem_arb: directed scenarios plus a randomized run,
// all compared against a cycle-level behavioural model of the arbitration rules.
module tb_dmem_arb;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int SMAX = 8;

    logic          clk = 1'b0;
    logic          RST;
    logic          cpu_re, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [31:0]   stall_cnt;

    int errors = 0;
    int checks = 0;

    dmem_arb #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .RST(RST),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Attached RAM (64 words used), asynchronous read, write on the clock edge
    logic [DW-1:0] ram [0:63];
    logic          pre_en;
    logic [5:0]    pre_a;
    logic [DW-1:0] pre_d;
    int            wr_cnt_020;

    assign mem_rdata = ram[mem_addr[5:0]];

    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_a] <= pre_d;
            wr_cnt_020 <= 0;
        end else if (mem_we) begin
            ram[mem_addr[5:0]] <= mem_wdata;
            if (mem_addr == 12'h020) wr_cnt_020 <= wr_cnt_020 + 1;
        end
    end

    // Behavioural model state
    logic [DW-1:0] ref_mem [0:63];
    bit            ack_due;
    int            lost;
    logic [DW-1:0] exp_dbg_rdata;
    logic [31:0]   exp_scnt;
    bit            e_grant, e_stall, e_we, e_ack;
    logic [AW-1:0] e_addr;

    task automatic model_reset();
        ack_due       = 0;
        lost          = 0;
        exp_dbg_rdata = '0;
        exp_scnt      = '0;
        e_stall       = 0;
    endtask

    // Drive one cycle of inputs and derive the expected port behaviour for it
    task automatic setup_cycle(input logic re, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] wd, input logic req, input logic [AW-1:0] da);
        @(negedge clk);
        cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        dbg_req = req; dbg_addr = da;
        #1;
        e_grant = !ack_due && req && (!(re || we) || (lost >= SMAX - 1));
        e_stall = e_grant && (re || we);
        e_we    = we && !e_grant;
        e_addr  = e_grant ? da : a;
        e_ack   = ack_due;
    endtask

    // Commit the model's view of the clock edge that ends the current cycle
    task automatic finish_cycle();
        if (e_grant) exp_dbg_rdata = ref_mem[dbg_addr[5:0]];
        if (e_we) ref_mem[cpu_addr[5:0]] = cpu_wdata;
        if (e_stall) exp_scnt = exp_scnt + 32'd1;
        if (e_grant || ack_due || !dbg_req) lost = 0;
        else lost = lost + 1;
        ack_due = e_grant;
        @(posedge clk);
    endtask

    task automatic test_reset();
        cpu_re = 1; cpu_we = 1; cpu_addr = 12'h005; cpu_wdata = 32'h1234_5678;
        dbg_req = 1; dbg_addr = 12'h007;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", cpu_stall); end
        checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", dbg_ack); end
        checks++; if (dbg_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", dbg_rdata); end
        checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
        @(negedge clk);
        RST = 0; cpu_re = 0; cpu_we = 0; dbg_req = 0;
        model_reset();
    endtask

    task automatic test_debug_idle();
        setup_cycle(0, 0, 12'h005, 32'h0, 1, 12'h010);
        checks++; if (mem_addr !== 12'h010) begin errors++; $display("FAIL idle_grant_addr got=%h exp=010", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL idle_grant_we got=%b exp=0", mem_we); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL idle_grant_stall got=%b exp=0", cpu_stall); end
        finish_cycle();
        setup_cycle(0, 0, 12'h005, 32'h0, 0, 12'h010);
        checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL idle_ack got=%b exp=1", dbg_ack); end
        checks++; if (dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_rdata got=%h exp=deadbeef", dbg_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL idle_ack_stall got=%b exp=0", cpu_stall); end
        finish_cycle();
        setup_cycle(0, 0, 12'h005, 32'h0, 0, 12'h010);
        checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL idle_ack_once got=%b exp=0", dbg_ack); end
        checks++; if (dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_rdata_hold got=%h exp=deadbeef", dbg_rdata); end
        finish_cycle();
    endtask

    task automatic test_cpu_load();
        logic [31:0] base;
        base = exp_scnt;
        setup_cycle(1, 0, 12'h030, 32'h0, 0, 12'h000);
        checks++; if (cpu_rdata !== ref_mem[6'h30]) begin errors++; $display("FAIL load_rdata got=%h exp=%h", cpu_rdata, ref_mem[6'h30]); end
        checks++; if (mem_addr !== 12'h030) begin errors++; $display("FAIL load_addr got=%h exp=030", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL load_we got=%b exp=0", mem_we); end
        finish_cycle();
        setup_cycle(0, 0, 12'h000, 32'h0, 0, 12'h000);
        checks++; if (stall_cnt !== base) begin errors++; $display("FAIL load_stall_cnt got=%0d exp=%0d", stall_cnt, base); end
        finish_cycle();
    endtask

    task automatic test_starve();
        logic [31:0]   base;
        logic [DW-1:0] wd;
        logic [AW-1:0] a;
        base = exp_scnt;
        wd = '0;
        for (int k = 0; k < 8; k++) begin
            wd = $urandom;
            a  = AW'(12'h028 + k);
            setup_cycle(0, 1, a, wd, 1, 12'h011);
            if (k < 7) begin
                checks++; if (cpu_stall !== 1'b0 || mem_we !== 1'b1 || mem_addr !== a) begin
                    errors++; $display("FAIL starve_cpu k=%0d got stall=%b we=%b addr=%h exp 0/1/%h", k, cpu_stall, mem_we, mem_addr, a);
                end
            end else begin
                checks++; if (cpu_stall !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h011) begin
                    errors++; $display("FAIL starve_forced got stall=%b we=%b addr=%h exp 1/0/011", cpu_stall, mem_we, mem_addr);
                end
            end
            finish_cycle();
        end
        setup_cycle(0, 1, 12'h02F, wd, 0, 12'h011);
        checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL starve_ack got=%b exp=1", dbg_ack); end
        checks++; if (stall_cnt !== base + 32'd1) begin errors++; $display("FAIL starve_stall_cnt got=%0d exp=%0d", stall_cnt, base + 32'd1); end
        checks++; if (dbg_rdata !== ref_mem[6'h11]) begin errors++; $display("FAIL starve_rdata got=%h exp=%h", dbg_rdata, ref_mem[6'h11]); end
        checks++; if (mem_we !== 1'b1 || cpu_stall !== 1'b0) begin errors++; $display("FAIL starve_retry got we=%b stall=%b exp 1/0", mem_we, cpu_stall); end
        finish_cycle();
    endtask

    task automatic test_forced_store();
        int base_wr;
        base_wr = wr_cnt_020;
        for (int k = 0; k < 7; k++) begin
            setup_cycle(1, 0, AW'(12'h03A + k), 32'h0, 1, 12'h012);
            checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL fstore_pre k=%0d got stall=%b exp=0", k, cpu_stall); end
            finish_cycle();
        end
        setup_cycle(0, 1, 12'h020, 32'h55, 1, 12'h012);
        checks++; if (cpu_stall !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL fstore_forced got stall=%b we=%b exp 1/0", cpu_stall, mem_we); end
        finish_cycle();
        setup_cycle(0, 1, 12'h020, 32'h55, 0, 12'h012);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 12'h020 || dbg_ack !== 1'b1) begin
            errors++; $display("FAIL fstore_retry got we=%b addr=%h ack=%b exp 1/020/1", mem_we, mem_addr, dbg_ack);
        end
        finish_cycle();
        setup_cycle(0, 0, 12'h000, 32'h0, 0, 12'h000);
        checks++; if (ram[6'h20] !== 32'h55) begin errors++; $display("FAIL fstore_ram got=%h exp=55", ram[6'h20]); end
        checks++; if (wr_cnt_020 - base_wr != 1) begin errors++; $display("FAIL fstore_once got=%0d exp=1", wr_cnt_020 - base_wr); end
        finish_cycle();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] da;
        int acks;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            da = AW'(12'h014 + k / 2);
            setup_cycle(0, 0, 12'h001, 32'h0, 1, da);
            checks++; if (dbg_ack !== ((k % 2) == 1)) begin errors++; $display("FAIL b2b_ack k=%0d got=%b exp=%b", k, dbg_ack, (k % 2) == 1); end
            if (dbg_ack === 1'b1) acks++;
            if ((k % 2) == 0) begin
                checks++; if (mem_addr !== da) begin errors++; $display("FAIL b2b_addr k=%0d got=%h exp=%h", k, mem_addr, da); end
            end else begin
                checks++; if (dbg_rdata !== ref_mem[da[5:0]]) begin errors++; $display("FAIL b2b_rdata k=%0d got=%h exp=%h", k, dbg_rdata, ref_mem[da[5:0]]); end
            end
            finish_cycle();
        end
        setup_cycle(0, 0, 12'h001, 32'h0, 0, 12'h000);
        checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL b2b_tail_ack got=%b exp=0", dbg_ack); end
        checks++; if (acks != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", acks); end
        finish_cycle();
    endtask

    task automatic test_reset_mid_wait();
        for (int k = 0; k < 5; k++) begin
            setup_cycle(1, 0, 12'h031, 32'h0, 1, 12'h013);
            checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL midrst_pre k=%0d got=%b exp=0", k, cpu_stall); end
            finish_cycle();
        end
        @(negedge clk);
        RST = 1; cpu_we = 1; dbg_req = 1;
        #1;
        checks++; if (dbg_ack !== 1'b0 || cpu_stall !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got ack=%b stall=%b we=%b exp 0/0/0", dbg_ack, cpu_stall, mem_we);
        end
        checks++; if (stall_cnt !== 32'h0 || dbg_rdata !== 32'h0) begin
            errors++; $display("FAIL midrst_regs got cnt=%0d rdata=%h exp 0/0", stall_cnt, dbg_rdata);
        end
        model_reset();
        @(negedge clk);
        RST = 0; cpu_re = 0; cpu_we = 0; dbg_req = 0;
        for (int k = 0; k < 8; k++) begin
            setup_cycle(1, 0, 12'h031, 32'h0, 1, 12'h013);
            checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL midrst_noack k=%0d got=%b exp=0", k, dbg_ack); end
            checks++; if (cpu_stall !== (k == 7)) begin errors++; $display("FAIL midrst_rereq k=%0d got=%b exp=%b", k, cpu_stall, k == 7); end
            finish_cycle();
        end
        setup_cycle(1, 0, 12'h031, 32'h0, 0, 12'h013);
        checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== ref_mem[6'h13]) begin
            errors++; $display("FAIL midrst_ack got ack=%b rdata=%h exp 1/%h", dbg_ack, dbg_rdata, ref_mem[6'h13]);
        end
        finish_cycle();
    endtask

    task automatic test_random();
        logic          re, we, req;
        logic [AW-1:0] a, da;
        logic [DW-1:0] wd;
        re = 0; we = 0; a = '0; wd = '0; req = 0; da = '0;
        for (int n = 0; n < 600; n++) begin
            if (!e_stall) begin
                re = ($urandom_range(0, 9) < 4);
                we = ($urandom_range(0, 9) < 3);
                a  = AW'($urandom_range(0, 63));
                wd = $urandom;
            end
            if (ack_due || !req) begin
                req = ($urandom_range(0, 2) == 0);
                da  = AW'($urandom_range(0, 63));
            end else begin
                req = ($urandom_range(0, 29) != 0);
            end
            setup_cycle(re, we, a, wd, req, da);
            checks++; if (cpu_stall !== e_stall) begin errors++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, cpu_stall, e_stall); end
            checks++; if (mem_we !== e_we) begin errors++; $display("FAIL rnd_we n=%0d got=%b exp=%b", n, mem_we, e_we); end
            checks++; if (mem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, mem_addr, e_addr); end
            checks++; if (dbg_ack !== e_ack) begin errors++; $display("FAIL rnd_ack n=%0d got=%b exp=%b", n, dbg_ack, e_ack); end
            checks++; if (dbg_rdata !== exp_dbg_rdata) begin errors++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, dbg_rdata, exp_dbg_rdata); end
            checks++; if (stall_cnt !== exp_scnt) begin errors++; $display("FAIL rnd_stall_cnt n=%0d got=%0d exp=%0d", n, stall_cnt, exp_scnt); end
            if (!e_grant && re && !we) begin
                checks++; if (cpu_rdata !== ref_mem[a[5:0]]) begin errors++; $display("FAIL rnd_load n=%0d got=%h exp=%h", n, cpu_rdata, ref_mem[a[5:0]]); end
            end
            if (e_we) begin
                checks++; if (mem_wdata !== wd) begin errors++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, mem_wdata, wd); end
            end
            finish_cycle();
        end
        setup_cycle(0, 0, 12'h000, 32'h0, 0, 12'h000);
        for (int i = 0; i < 64; i++) begin
            checks++; if (ram[i] !== ref_mem[i]) begin errors++; $display("FAIL rnd_ram addr=%0d got=%h exp=%h", i, ram[i], ref_mem[i]); end
        end
        finish_cycle();
    endtask

    initial begin
        RST = 1; pre_en = 1; pre_a = '0; pre_d = '0;
        cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; dbg_req = 0; dbg_addr = '0;
        model_reset();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pre_a = 6'(i);
            pre_d = (i == 16) ? 32'hDEADBEEF : $urandom;
            ref_mem[i] = pre_d;
        end
        @(negedge clk);
        pre_en = 0;
        test_reset();
        test_debug_idle();
        test_cpu_load();
        test_starve();
        test_forced_store();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
